// File: rtl/decoder_3to8_pending.sv
// decoder_3to8_pending
// Registered 3-to-8 decoder that also tracks which decoded lines are still
// waiting for the consumer. Each accepted code produces a one-cycle one-hot
// pulse and sets its pending bit. The consumer retires lines through ack.
// A code that arrives for a line that is still pending raises a sticky
// overflow flag.

module decoder_3to8_pending (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  input  logic [7:0] ack,
  input  logic       clr_ovf,
  output logic [7:0] onehot,
  output logic [7:0] pending,
  output logic [3:0] count,
  output logic       any,
  output logic       overflow
);

  // Population count of an 8-bit vector (result range 0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  logic [7:0] decode;
  logic [7:0] pending_nxt;
  logic [3:0] count_nxt;
  logic       ovf_event;
  logic       overflow_nxt;

  // Decode the accepted code and work out the next pending, count and overflow.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one holding its old value and infer a latch.
    decode       = 8'h00;
    pending_nxt  = 8'h00;
    count_nxt    = 4'd0;
    ovf_event    = 1'b0;
    overflow_nxt = 1'b0;

    // in_code is only looked at while in_valid is high, so an X or a changing
    // value on in_code in idle cycles cannot leak into the state.
    if (in_valid) begin
      decode = 8'h01 << in_code;
    end

    // Acks retire lines first. A new set is ORed in afterwards, so a set beats
    // a same-cycle ack of the same line. Acks of idle lines fall out as no-ops.
    pending_nxt = (pending & ~ack) | decode;

    // A repeat request only overflows if the old one is not retiring this cycle.
    if (in_valid) begin
      ovf_event = pending[in_code] & ~ack[in_code];
    end

    // Sticky flag. A new event wins over a same-cycle clear.
    overflow_nxt = ovf_event | (overflow & ~clr_ovf);

    // Count follows the value pending is about to take, so the two registers
    // always agree.
    count_nxt = popcount8(pending_nxt);
  end

  // State registers. Reset is asynchronous and clears everything, including the
  // one-hot pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all registers see the pre-edge values of each other.
    if (rst) begin
      onehot   <= 8'h00;
      pending  <= 8'h00;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      onehot   <= decode;
      pending  <= pending_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
    end
  end

  assign any = |pending;

endmodule

// File: tb/tb_decoder_3to8_pending.sv
// tb_decoder_3to8_pending
// Self-checking bench for decoder_3to8_pending: a directed vector table, a few
// hand-written reset sequences, and randomized traffic compared against a
// per-line behavioural model.

module tb_decoder_3to8_pending;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic [7:0] ack;
  logic       clr_ovf;
  logic [7:0] onehot;
  logic [7:0] pending;
  logic [3:0] count;
  logic       any;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  decoder_3to8_pending dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .ack      (ack),
    .clr_ovf  (clr_ovf),
    .onehot   (onehot),
    .pending  (pending),
    .count    (count),
    .any      (any),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic [7:0] ack;
    logic       clr;
    logic [7:0] exp_oh;
    logic [7:0] exp_pend;
    logic [3:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: one flag per line, plus the sticky flag and the last pulse.
  bit       m_line[8];
  bit       m_ovf;
  bit [7:0] m_oh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_oh, input logic [7:0] e_pend,
                           input logic [3:0] e_cnt, input logic e_ovf);
    check({tag, " onehot"},   {24'd0, onehot},  {24'd0, e_oh});
    check({tag, " pending"},  {24'd0, pending}, {24'd0, e_pend});
    check({tag, " count"},    {28'd0, count},   {28'd0, e_cnt});
    check({tag, " any"},      {31'd0, any},     {31'd0, (e_pend != 8'h00)});
    check({tag, " overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
  endtask

  // Drive inputs (we sit 1 time unit after a rising edge), clock once, settle.
  task automatic step(input logic v, input logic [2:0] code, input logic [7:0] a, input logic c);
    in_valid = v;
    in_code  = code;
    ack      = a;
    clr_ovf  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic v, input logic [2:0] code, input logic [7:0] a, input logic c,
                         input logic [7:0] e_oh, input logic [7:0] e_pend, input logic [3:0] e_cnt,
                         input logic e_ovf);
    vec_t t;
    t.v = v; t.code = code; t.ack = a; t.clr = c;
    t.exp_oh = e_oh; t.exp_pend = e_pend; t.exp_cnt = e_cnt; t.exp_ovf = e_ovf;
    vecs.push_back(t);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_line[i] = 1'b0;
    m_ovf = 1'b0;
    m_oh  = 8'h00;
  endtask

  // Advance the model by one edge from the rules: a new request keeps its line
  // pending, otherwise an ack retires it; a repeat request for a line that is
  // pending and not being acked is an overflow.
  task automatic model_step(input bit v, input bit [2:0] code, input bit [7:0] a, input bit c);
    bit was[8];
    bit hit;
    for (int i = 0; i < 8; i++) was[i] = m_line[i];
    hit = v && was[code] && !a[code];
    for (int i = 0; i < 8; i++) begin
      if (v && code == i)  m_line[i] = 1'b1;
      else if (a[i])       m_line[i] = 1'b0;
      m_oh[i] = v && (code == i);
    end
    if (hit)    m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_line[i];
    return p;
  endfunction

  function automatic logic [3:0] model_cnt();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (m_line[i]) n++;
    return 4'(n);
  endfunction

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_code = 3'd0; ack = 8'h00; clr_ovf = 1'b0;

    // Asynchronous reset assertion before any clock edge.
    #3 rst = 1'b1;
    #1 check_all("reset_async", 8'h00, 8'h00, 4'd0, 1'b0);

    // Inputs are ignored while reset is held across edges.
    in_valid = 1'b1; in_code = 3'd1; ack = 8'hFF; clr_ovf = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_hold", 8'h00, 8'h00, 4'd0, 1'b0);
    rst = 1'b0;

    // Directed vector table, applied back to back from the reset state.
    add_vec(1, 3'd5, 8'h00, 0, 8'h20, 8'h20, 4'd1, 0);   // first code after reset
    add_vec(0, 3'd0, 8'h00, 0, 8'h00, 8'h20, 4'd1, 0);   // pulse is one cycle only
    add_vec(0, 3'd0, 8'hFF, 0, 8'h00, 8'h00, 4'd0, 0);   // ack retires it
    add_vec(0, 3'd0, 8'hFF, 0, 8'h00, 8'h00, 4'd0, 0);   // empty + ack all ones
    for (int k = 0; k < 8; k++)
      add_vec(1, 3'(k), 8'h00, 0, 8'(1 << k), 8'((1 << (k + 1)) - 1), 4'(k + 1), 0);
    add_vec(1, 3'd2, 8'h00, 0, 8'h04, 8'hFF, 4'd8, 1);   // full: repeat overflows
    add_vec(1, 3'd3, 8'h00, 1, 8'h08, 8'hFF, 4'd8, 1);   // new event beats clear
    add_vec(0, 3'd0, 8'h00, 1, 8'h00, 8'hFF, 4'd8, 0);   // clear alone
    add_vec(0, 3'd0, 8'hFB, 0, 8'h00, 8'h04, 4'd1, 0);   // leave only line 2
    add_vec(1, 3'd2, 8'h04, 0, 8'h04, 8'h04, 4'd1, 0);   // set+ack same line: no overflow
    add_vec(0, 3'd0, 8'h00, 0, 8'h00, 8'h04, 4'd1, 0);   // hold
    add_vec(1, 3'd7, 8'h04, 0, 8'h80, 8'h80, 4'd1, 0);   // retire 2, set 7
    add_vec(1, 3'd0, 8'h00, 0, 8'h01, 8'h81, 4'd2, 0);   // pending 81
    add_vec(0, 3'd0, 8'hFF, 0, 8'h00, 8'h00, 4'd0, 0);   // ack all
    add_vec(1, 3'd6, 8'h40, 0, 8'h40, 8'h40, 4'd1, 0);   // ack of idle line ignored
    add_vec(0, 3'bxxx, 8'h00, 0, 8'h00, 8'h40, 4'd1, 0); // X code while idle

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].code, vecs[i].ack, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_oh, vecs[i].exp_pend,
                vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Mid-operation reset: build pending 3C with overflow, then pulse rst between edges.
    step(0, 3'd0, 8'hFF, 1);
    step(1, 3'd2, 8'h00, 0);
    step(1, 3'd3, 8'h00, 0);
    step(1, 3'd4, 8'h00, 0);
    step(1, 3'd5, 8'h00, 0);
    step(1, 3'd3, 8'h00, 0);
    check_all("pre_reset", 8'h08, 8'h3C, 4'd4, 1'b1);
    #2 rst = 1'b1;
    #1 check_all("mid_reset", 8'h00, 8'h00, 4'd0, 1'b0);
    #1 rst = 1'b0;
    step(1, 3'd0, 8'h00, 0);
    check_all("post_reset", 8'h01, 8'h01, 4'd1, 1'b0);

    // Randomized traffic against the model, starting from a fresh reset.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic       v;
      logic [2:0] code;
      logic [7:0] a;
      logic       c;
      v    = ($urandom_range(0, 3) != 0);
      code = v ? 3'($urandom_range(0, 7)) : 3'bxxx;
      a    = 8'($urandom & $urandom & $urandom);
      c    = ($urandom_range(0, 7) == 0);
      step(v, code, a, c);
      model_step(v, v ? code : 3'd0, a, c);
      check_all($sformatf("rand%0d", n), m_oh, model_pend(), model_cnt(), m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_pending.md
DECODER_3TO8_PENDING -- requirements
Module: decoder_3to8_pending

Interface
REQ-001 The block SHALL have a single clock: clk, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have a reset: rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have in_valid, input, 1: the code on in_code is presented this cycle.
REQ-004 The block SHALL have in_code, input, 3: binary index 0..7, as produced by an 8:3 priority encoder.
REQ-005 The block SHALL have ack, input, 8: per-line clear mask from the consumer; bit i clears pending line i.
REQ-006 The block SHALL have clr_ovf, input, 1: synchronous clear of the sticky overflow flag.
REQ-007 The block SHALL have onehot, output, 8, registered: one-cycle one-hot decode of the code accepted on the previous edge.
REQ-008 The block SHALL have pending, output, 8, registered: set of decoded lines not yet acknowledged.
REQ-009 The block SHALL have count, output, 4, registered: population count of pending (0..8).
REQ-010 The block SHALL have any, output, 1: equal to the OR of all pending bits, derived combinationally from the pending register.
REQ-011 The block SHALL have overflow, output, 1, registered, sticky: a code arrived for a line that was already pending.

Function
REQ-012 The decode SHALL map in_code k to bit k of an 8-bit vector, with all other bits 0.
REQ-013 On a rising edge with in_valid=1, onehot SHALL become the decode of in_code. On a rising edge with in_valid=0, onehot SHALL become 8'h00. Latency is 1 cycle and onehot is never held.
REQ-014 The next value of pending SHALL be computed in two steps: (pending & ~ack), then OR the decode of in_code when in_valid=1. Set has priority over a same-cycle ack of the same line.
REQ-015 Ack bits for lines that are not pending SHALL be ignored, with no error and no state change.
REQ-016 Overflow SHALL set on an edge where in_valid=1, pending[in_code]=1 and ack[in_code]=0. The line stays pending with no double counting.
REQ-017 A same-cycle ack of the same line SHALL suppress overflow, because the old request retires as the new one arrives.
REQ-018 Overflow SHALL clear only on clr_ovf=1. If a new overflow condition occurs in the same cycle as clr_ovf, overflow SHALL be set, so set wins.
REQ-019 count SHALL equal the popcount of the next pending value, registered alongside pending so that count always matches pending in the same cycle.
REQ-020 Boundary, full: with pending=8'hFF and count=8, a new valid code SHALL raise overflow, and count SHALL stay at 8.
REQ-021 Boundary, empty: with pending=0, an ack of all ones SHALL leave pending=0 and count=0.
REQ-022 in_code SHALL be sampled only when in_valid=1. X or changing values on in_code while in_valid=0 SHALL have no effect.

Reset
REQ-023 Asserting rst SHALL immediately force onehot=8'h00, pending=8'h00, count=0 and overflow=0, independent of clk.
REQ-024 While rst=1, in_valid, ack and clr_ovf SHALL be ignored.
REQ-025 After rst deasserts, the first rising edge SHALL process inputs normally.
REQ-026 Reset asserted mid-operation SHALL discard all pending lines without producing an onehot pulse.

Verification
REQ-027 Scenario: reset, then in_valid=1 with in_code=3'b101 for one cycle. Required response: next cycle onehot=8'h20, pending=8'h20, count=1, any=1; the cycle after that, onehot=8'h00 and pending is still 8'h20.
REQ-028 Scenario: load codes 0 through 7 on consecutive cycles, then send code 2 again. Required response: pending=8'hFF and count=8, then overflow=1 while count stays 8.
REQ-029 Scenario: pending=8'h04, then in_valid=1 with code 2 and ack=8'h04 on the same edge. Required response: pending=8'h04, count=1, overflow=0.
REQ-030 Scenario: pending=8'h81, then ack=8'hFF with in_valid=0. Required response: pending=8'h00, count=0, any=0, onehot=8'h00.
REQ-031 Scenario: overflow=1, then clr_ovf=1 on the same edge as a new overflow event. Required response: overflow stays 1. Then clr_ovf=1 alone gives overflow=0.
REQ-032 Scenario: pending=8'h3C with overflow=1, then rst pulsed between clock edges. Required response: all outputs go to 0 before the next edge, and the first post-reset code 0 gives onehot=8'h01 and count=1.
